// File: rtl/gpi_pkg.sv
// gpi_pkg: register offsets, register enum and APB data width shared by the GPI peripheral.
package gpi_pkg;

    localparam int APB_DW = 32;

    localparam logic [2:0] GPI_CR   = 3'd0;
    localparam logic [2:0] GPI_IDR  = 3'd1;
    localparam logic [2:0] GPI_IER  = 3'd2;
    localparam logic [2:0] GPI_EDGE = 3'd3;
    localparam logic [2:0] GPI_ISR  = 3'd4;

    typedef enum logic [2:0] {
        REG_CR   = GPI_CR,
        REG_IDR  = GPI_IDR,
        REG_IER  = GPI_IER,
        REG_EDGE = GPI_EDGE,
        REG_ISR  = GPI_ISR
    } gpi_reg_e;

endpackage

// File: rtl/gpi_in_cond.sv
// gpi_in_cond: one-pin conditioner (synchroniser, debounce when GPI_DEBOUNCE_EN is defined, edge outputs).
module gpi_in_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_LEN      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic filt,
    output logic prev,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sr;
    logic                   sync;

    // shift the asynchronous pin through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[SYNC_STAGES-2:0], pin};
    end

    assign sync = sr[SYNC_STAGES-1];

`ifdef GPI_DEBOUNCE_EN
    localparam int CW = $clog2(DB_LEN + 1);

    logic [CW-1:0] cnt;

    // accept the new level only after DB_LEN consecutive cycles of disagreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (sync == filt) begin
            cnt  <= '0;
        end else if (cnt == CW'(DB_LEN - 1)) begin
            filt <= sync;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end
`else
    assign filt = sync;
`endif

    // prev follows filt every cycle so enabling a pin never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= filt;
    end

    assign rise = filt & ~prev;
    assign fall = ~filt & prev;

endmodule

// File: rtl/apb_gpi_irq.sv
// apb_gpi_irq: APB3 general-purpose input block with edge interrupts; GPI_DEBOUNCE_EN adds per-pin debounce.
module apb_gpi_irq
    import gpi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_LEN      = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [4:0]        PADDR,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic [31:0]       PWDATA,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    input  logic [WIDTH-1:0]  gpi,
    output logic              irq
);

    logic [WIDTH-1:0]  cr, ier, edge_sel, isr;
    logic [WIDTH-1:0]  filt, prev, rise, fall, hit, w1c, wdata;
    logic [2:0]        off;
    logic              access, wr;
    logic [APB_DW-1:0] rdata;
    logic              unused_ok;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpi_in_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_LEN      (DB_LEN)
        ) u_cond (
            .clk   (PCLK),
            .rst_n (PRESET),
            .pin   (gpi[i]),
            .filt  (filt[i]),
            .prev  (prev[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign unused_ok = ^{PADDR[1:0], PWDATA, prev};
    assign off       = PADDR[4:2];
    assign wdata     = PWDATA[WIDTH-1:0];
    assign access    = PSEL & PENABLE & ~PREADY;
    assign wr        = access & PWRITE;
    assign hit       = cr & ((edge_sel & fall) | (~edge_sel & rise));
    assign w1c       = (wr && off == GPI_ISR) ? wdata : '0;
    assign irq       = |(isr & ier);

    // read mux; unmapped offsets and bits above WIDTH read as zero
    always_comb begin
        rdata = '0;
        rdata[WIDTH-1:0] = off == GPI_CR   ? cr :
                           off == GPI_IDR  ? filt & cr :
                           off == GPI_IER  ? ier :
                           off == GPI_EDGE ? edge_sel :
                           off == GPI_ISR  ? isr : '0;
    end

    // one-wait-state APB handshake, register writes and sticky status with set priority
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            PREADY   <= 1'b0;
            PRDATA   <= '0;
            cr       <= '0;
            ier      <= '0;
            edge_sel <= '0;
            isr      <= '0;
        end else begin
            PREADY <= access;
            if (access && !PWRITE)       PRDATA   <= rdata;
            if (wr && off == GPI_CR)     cr       <= wdata;
            if (wr && off == GPI_IER)    ier      <= wdata;
            if (wr && off == GPI_EDGE)   edge_sel <= wdata;
            isr <= (isr & ~w1c) | hit;
        end
    end

endmodule

// File: tb/tb_apb_gpi_irq.sv
// tb_apb_gpi_irq: randomized scoreboard bench for apb_gpi_irq; the GPI_DEBOUNCE_EN build adds pulse tests.
module tb_apb_gpi_irq;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DB = 4;
`ifdef GPI_DEBOUNCE_EN
    localparam int LAT = SS + DB;
`else
    localparam int LAT = SS;
`endif

    logic          PCLK = 0, PRESET = 0, PWRITE = 0, PENABLE = 0, PSEL = 0;
    logic [4:0]    PADDR = 0;
    logic [31:0]   PWDATA = 0;
    logic [31:0]   PRDATA;
    logic          PREADY, irq;
    logic [W-1:0]  gpi = '1;

    int            checks = 0, errors = 0;
    logic [31:0]   exp_q[$];
    logic [W-1:0]  m_cr = 0, m_ier = 0, m_edge = 0, m_isr = 0, m_gpi = '1;
    logic          ready_d = 0;

    apb_gpi_irq #(.WIDTH(W), .SYNC_STAGES(SS), .DB_LEN(DB)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .gpi(gpi), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] off);
        logic [W-1:0] v;
        v = off == 3'd0 ? m_cr : off == 3'd1 ? (m_gpi & m_cr) : off == 3'd2 ? m_ier :
            off == 3'd3 ? m_edge : off == 3'd4 ? m_isr : '0;
        return 32'(v);
    endfunction

    // monitor: every completed read pops the scoreboard; PREADY must be a one-cycle pulse
    always @(posedge PCLK) begin
        #1;
        if (PREADY) begin
            chk("pready_pulse", 32'(ready_d), 0);
            if (!PWRITE) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_queue: got read data %h with no expected entry", PRDATA);
                end else begin
                    chk("prdata", PRDATA, exp_q.pop_front());
                end
            end
        end
        ready_d = PREADY;
    end

    task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d);
        int n;
        PSEL = 1; PWRITE = w; PADDR = a; PWDATA = d; PENABLE = 0;
        @(negedge PCLK) PENABLE = 1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 8);
        chk("wait_states", n, 1);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        xfer(1, a, d);
        case (a[4:2])
            3'd0: m_cr = d[W-1:0];
            3'd2: m_ier = d[W-1:0];
            3'd3: m_edge = d[W-1:0];
            3'd4: m_isr = m_isr & ~d[W-1:0];
            default: ;
        endcase
    endtask

    task automatic rd(input logic [4:0] a);
        exp_q.push_back(model_rd(a[4:2]));
        xfer(0, a, 0);
    endtask

    function automatic logic [W-1:0] events(input logic [W-1:0] v);
        return m_cr & ((m_edge & m_gpi & ~v) | (~m_edge & ~m_gpi & v));
    endfunction

    task automatic set_gpi(input logic [W-1:0] v);
        logic [W-1:0] ev;
        ev = events(v);
        gpi = v;
        repeat (LAT + 3) @(negedge PCLK);
        m_gpi = v;
        m_isr = m_isr | ev;
    endtask

    task automatic chk_irq(input string name);
        chk(name, 32'(irq), 32'(|(m_isr & m_ier)));
    endtask

    initial begin
        logic [W-1:0] ev;
        int n;
        @(negedge PCLK);
        repeat (3) @(negedge PCLK);
        chk("rst_pready", 32'(PREADY), 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_irq", 32'(irq), 0);
        PRESET = 1;
        repeat (LAT + 2) @(negedge PCLK);
        rd(5'h04); rd(5'h10); chk_irq("t1_irq");

        wr(5'h00, 32'h0F); set_gpi(8'hA5);
        rd(5'h04); rd(5'h18);
        wr(5'h1C, 32'hFFFF_FFFF);
        rd(5'h00); rd(5'h08); rd(5'h0C); rd(5'h10);

        wr(5'h08, 32'h03); wr(5'h0C, 32'h02);
        set_gpi(8'hA6); rd(5'h10); chk_irq("t3_no_event");
        set_gpi(8'hA5); rd(5'h10); chk_irq("t3_irq_set");
        wr(5'h10, 32'h01); chk_irq("t3_irq_keep"); rd(5'h10);
        wr(5'h10, 32'h02); chk_irq("t3_irq_clear");

        wr(5'h10, 32'h00); rd(5'h10);
        set_gpi(8'hA4);
        ev = events(8'hA5);
        gpi = 8'hA5;
        repeat (LAT - 1) @(negedge PCLK);
        wr(5'h10, 32'h01);
        m_isr = m_isr | ev;
        m_gpi = 8'hA5;
        repeat (4) @(negedge PCLK);
        rd(5'h10);
        wr(5'h08, 32'h02); wr(5'h10, 32'h01);
        set_gpi(8'hA4); set_gpi(8'hA5); chk_irq("t4_masked"); rd(5'h10);

        set_gpi(8'hA1); set_gpi(8'hA5);
        wr(5'h00, 32'h0B);
        set_gpi(8'hA1); set_gpi(8'hA5); rd(5'h10);
        wr(5'h00, 32'h0F); rd(5'h10); rd(5'h04);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: set_gpi(W'($urandom));
                1: wr(5'h00, $urandom);
                2: wr(5'h08, $urandom);
                3: wr(5'h0C, $urandom);
                default: wr(5'h10, $urandom);
            endcase
            rd(5'h10); rd(5'h04); chk_irq("rand_irq");
        end

`ifdef GPI_DEBOUNCE_EN
        wr(5'h00, 32'h01); wr(5'h0C, 32'h00); wr(5'h08, 32'h01); wr(5'h10, 32'hFF);
        set_gpi({m_gpi[W-1:1], 1'b0});
        gpi[0] = 1'b1;
        repeat (3) @(negedge PCLK);
        gpi[0] = 1'b0;
        repeat (LAT + 3) @(negedge PCLK);
        chk_irq("db_short_pulse"); rd(5'h04); rd(5'h10);
        gpi[0] = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
            if (n == 6) gpi[0] = 1'b0;
        end while (!irq && n < 20);
        chk("db_latency", n, SS + DB + 1);
        m_isr = m_isr | 1;
        repeat (LAT + 3) @(negedge PCLK);
        rd(5'h10); chk_irq("db_irq");
`endif

        wr(5'h00, 32'hFF); rd(5'h00);
        PSEL = 1; PWRITE = 0; PADDR = 5'h04; PENABLE = 0;
        @(negedge PCLK) PENABLE = 1;
        #2 PRESET = 0;
        @(negedge PCLK);
        chk("midrst_pready", 32'(PREADY), 0);
        chk("midrst_prdata", PRDATA, 0);
        chk("midrst_irq", 32'(irq), 0);
        PSEL = 0; PENABLE = 0;
        m_cr = 0; m_ier = 0; m_edge = 0; m_isr = 0;
        @(negedge PCLK) PRESET = 1;
        repeat (LAT + 2) @(negedge PCLK);
        rd(5'h00); rd(5'h10); chk_irq("post_rst_irq");

        repeat (3) @(negedge PCLK);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
